// File: rtl/sipo_pkg.sv
// Shared encodings and K28.5 constants for the serial-to-parallel aligner.
package sipo_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;

  // True when a 10-bit word is K28.5 of either running disparity.
  function automatic logic is_k28_5(input logic [9:0] word);
    return (word == K28_5_RDN) || (word == K28_5_RDP);
  endfunction

endpackage

// File: rtl/sipo_shift.sv
// Serial shift register plus word-position counter; the window includes the
// bit currently on serial_in so callers can act on it in the same cycle.
module sipo_shift #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reinicio,
  input  logic             enable,
  input  logic             serial_in,
  input  logic             i_cnt_clr,
  output logic [WIDTH-1:0] o_window,
  output logic             o_boundary
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_window;
  logic             w_boundary;

  assign w_window   = {r_shift[WIDTH-2:0], serial_in};
  assign w_boundary = enable && (r_cnt == CW'(WIDTH - 1));
  assign o_window   = w_window;
  assign o_boundary = w_boundary;

  always_ff @(posedge clk) begin
    if (reinicio) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (enable) begin
      r_shift <= w_window;
      // A clear realigns the next received bit to word position 0.
      if (i_cnt_clr || w_boundary) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sipo_aligner.sv
// Serial-to-parallel converter with comma-based word alignment and lock FSM.
// Alignment logic is compiled in only when SIPO_ALIGNER_ALIGN_EN is defined.
module sipo_aligner
  import sipo_pkg::*;
#(
  parameter int               WIDTH    = 10,
  parameter logic [WIDTH-1:0] COMMA    = WIDTH'(K28_5_RDN),
  parameter int               LOCK_CNT = 3,
  parameter int               LOSS_CNT = 4
) (
  input  logic             clk,
  input  logic             reinicio,
  input  logic             serial_in,
  input  logic             enable,
  output logic [WIDTH-1:0] parallel_out,
  output logic             valid,
  output logic             locked,
  output logic             comma_det,
  output state_t           o_dbg_state
);

  // Handshake: valid is a one-cycle strobe with no back-pressure; parallel_out
  // carries the new word in exactly the cycle valid is high and holds after.

  logic [WIDTH-1:0] w_window;
  logic             w_boundary;
  logic             w_cnt_clr;
  logic             w_load;
  logic [WIDTH-1:0] r_word;
  logic             r_valid;

  sipo_shift #(.WIDTH(WIDTH)) u_shift (
    .clk        (clk),
    .reinicio   (reinicio),
    .enable     (enable),
    .serial_in  (serial_in),
    .i_cnt_clr  (w_cnt_clr),
    .o_window   (w_window),
    .o_boundary (w_boundary)
  );

`ifdef SIPO_ALIGNER_ALIGN_EN
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(LOSS_CNT + 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [GW-1:0]   r_good;
  logic [GW-1:0]   w_good_nxt;
  logic [MW-1:0]   r_miss;
  logic [MW-1:0]   w_miss_nxt;
  logic            w_comma;
  logic            r_comma_det;

  assign w_comma = enable && ((w_window == COMMA) || (w_window == ~COMMA));

  always_ff @(posedge clk) begin
    if (reinicio) begin
      r_state     <= SEARCH;
      r_good      <= '0;
      r_miss      <= '0;
      r_comma_det <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_good      <= w_good_nxt;
      r_miss      <= w_miss_nxt;
      r_comma_det <= w_comma;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_miss_nxt  = r_miss;
    w_load      = 1'b0;
    w_cnt_clr   = 1'b0;
    if (enable) begin
      case (r_state)
        SEARCH: begin
          if (w_comma) begin
            w_cnt_clr   = 1'b1;
            w_load      = 1'b1;
            w_good_nxt  = GW'(1);
            w_miss_nxt  = '0;
            w_state_nxt = (LOCK_CNT <= 1) ? LOCKED : CHECK;
          end
        end
        CHECK: begin
          if (w_comma && !w_boundary) begin
            // Comma at the wrong phase: realign on it but restart acquisition.
            w_cnt_clr   = 1'b1;
            w_load      = 1'b1;
            w_good_nxt  = '0;
            w_state_nxt = SEARCH;
          end else if (w_boundary) begin
            w_load = 1'b1;
            if (w_comma) begin
              w_good_nxt = r_good + GW'(1);
              if (int'(r_good) + 1 >= LOCK_CNT) begin
                w_state_nxt = LOCKED;
                w_miss_nxt  = '0;
              end
            end
          end
        end
        LOCKED: begin
          if (w_boundary) begin
            w_load = 1'b1;
            if (w_comma) begin
              w_miss_nxt = '0;
            end
          end else if (w_comma) begin
            // Misplaced commas are tolerated up to LOSS_CNT; no realignment here.
            if (int'(r_miss) + 1 >= LOSS_CNT) begin
              w_miss_nxt  = '0;
              w_good_nxt  = '0;
              w_state_nxt = SEARCH;
            end else begin
              w_miss_nxt = r_miss + MW'(1);
            end
          end
        end
        default: begin
          w_state_nxt = SEARCH;
          w_good_nxt  = '0;
          w_miss_nxt  = '0;
        end
      endcase
    end
  end

  assign locked      = (r_state == LOCKED);
  assign comma_det   = r_comma_det;
  assign o_dbg_state = r_state;
`else
  logic w_unused_cfg;

  assign w_cnt_clr    = 1'b0;
  assign w_load       = w_boundary;
  assign locked       = 1'b1;
  assign comma_det    = 1'b0;
  assign o_dbg_state  = LOCKED;
  assign w_unused_cfg = (^COMMA) ^ (LOCK_CNT < 1) ^ (LOSS_CNT < 1);
`endif

  always_ff @(posedge clk) begin
    if (reinicio) begin
      r_word  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_load;
      if (w_load) begin
        r_word <= w_window;
      end
    end
  end

  assign parallel_out = r_word;
  assign valid        = r_valid;

endmodule

// File: tb/tb_sipo_aligner.sv
// Self-checking bench for sipo_aligner: bit-queue reference model checked
// every cycle, plus literal expectations on directed streams.
module tb_sipo_aligner;
  import sipo_pkg::*;

  localparam int           W       = 10;
  localparam logic [W-1:0] COMMA_P = 10'b0011111010;
  localparam int           LOCK_P  = 3;
  localparam int           LOSS_P  = 4;
  localparam logic [W-1:0] DATA_A  = 10'b1011010110;
  localparam logic [W-1:0] DATA_B  = 10'b1100110011;
  localparam int           M_SEARCH = 0;
  localparam int           M_CHECK  = 1;
  localparam int           M_LOCKED = 2;

  logic         clk = 1'b0;
  logic         reinicio = 1'b1;
  logic         serial_in = 1'b0;
  logic         enable = 1'b0;
  logic [W-1:0] parallel_out;
  logic         valid;
  logic         locked;
  logic         comma_det;
  state_t       dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  // Reference model state
  logic         m_bits[$];
  logic         m_armed = 1'b0;
  logic [W-1:0] m_word = '0;
  logic         m_valid = 1'b0;
  logic         m_locked = 1'b0;
  logic         m_comma = 1'b0;
  int           m_mode = M_SEARCH;
  int           m_pos = 0;
  int           m_good = 0;
  int           m_miss = 0;

  sipo_aligner #(
    .WIDTH    (W),
    .COMMA    (COMMA_P),
    .LOCK_CNT (LOCK_P),
    .LOSS_CNT (LOSS_P)
  ) dut (
    .clk          (clk),
    .reinicio     (reinicio),
    .serial_in    (serial_in),
    .enable       (enable),
    .parallel_out (parallel_out),
    .valid        (valid),
    .locked       (locked),
    .comma_det    (comma_det),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] last_word();
    logic [W-1:0] w;
    int sz;
    sz = m_bits.size();
    for (int k = 0; k < W; k++) w[W-1-k] = m_bits[sz-W+k];
    return w;
  endfunction

  task automatic emit(input logic [W-1:0] w);
    m_word  = w;
    m_valid = 1'b1;
    exp_q.push_back(w);
  endtask

  // ---------------- reference model ----------------
  always @(posedge clk) begin
    logic [W-1:0] win;
    logic         is_c;
    logic         at_b;
    logic         realign;
    if (reinicio) begin
      m_bits.delete();
      for (int k = 0; k < W; k++) m_bits.push_back(1'b0);
      m_word  = '0;
      m_valid = 1'b0;
      m_comma = 1'b0;
      m_mode  = M_SEARCH;
      m_pos   = 0;
      m_good  = 0;
      m_miss  = 0;
      exp_q.delete();
    end else begin
      m_valid = 1'b0;
      m_comma = 1'b0;
      if (enable) begin
        m_bits.push_back(serial_in);
        if (m_bits.size() > W) void'(m_bits.pop_front());
        win     = last_word();
        at_b    = (m_pos == W - 1);
        realign = 1'b0;
`ifdef SIPO_ALIGNER_ALIGN_EN
        is_c    = (win == COMMA_P) || (win == ~COMMA_P);
        m_comma = is_c;
        case (m_mode)
          M_SEARCH: if (is_c) begin
            realign = 1'b1;
            m_good  = 1;
            m_miss  = 0;
            m_mode  = (LOCK_P <= 1) ? M_LOCKED : M_CHECK;
          end
          M_CHECK: begin
            if (is_c && !at_b) begin
              realign = 1'b1;
              m_good  = 0;
              m_mode  = M_SEARCH;
            end else if (at_b) begin
              emit(win);
              if (is_c) begin
                m_good++;
                if (m_good >= LOCK_P) begin
                  m_mode = M_LOCKED;
                  m_miss = 0;
                end
              end
            end
          end
          default: begin
            if (at_b) begin
              emit(win);
              if (is_c) m_miss = 0;
            end else if (is_c) begin
              m_miss++;
              if (m_miss >= LOSS_P) begin
                m_miss = 0;
                m_good = 0;
                m_mode = M_SEARCH;
              end
            end
          end
        endcase
        if (realign) emit(win);
`else
        is_c = 1'b0;
        if (at_b) emit(win);
`endif
        m_pos = (at_b || realign || is_c && 1'b0) ? 0 : m_pos + 1;
      end
    end
`ifdef SIPO_ALIGNER_ALIGN_EN
    m_locked = (m_mode == M_LOCKED);
`else
    m_locked = 1'b1;
`endif
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [W-1:0] w;
    if (m_armed) begin
      chk("valid", 32'(valid), 32'(m_valid));
      chk("parallel_out", 32'(parallel_out), 32'(m_word));
      chk("locked", 32'(locked), 32'(m_locked));
      chk("comma_det", 32'(comma_det), 32'(m_comma));
`ifdef SIPO_ALIGNER_ALIGN_EN
      chk("state", 32'(dbg_state), 32'(m_mode));
`endif
      if (valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL word_q unexpected word got=%0h expected=none", parallel_out);
        end else begin
          w = exp_q.pop_front();
          chk("word_q", 32'(parallel_out), 32'(w));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic b, input logic en);
    serial_in = b;
    enable    = en;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int hi, input int lo);
    for (int k = hi; k >= lo; k--) drive(w[k], 1'b1);
  endtask

  task automatic send_word(input logic [W-1:0] w);
    send_bits(w, W - 1, 0);
  endtask

  task automatic do_reset();
    reinicio  = 1'b1;
    enable    = 1'b1;
    serial_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reinicio = 1'b0;
  endtask

  task automatic random_stream(input int n);
    for (int i = 0; i < n; i++) drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    do_reset();
    m_armed = 1'b1;
`ifdef SIPO_ALIGNER_ALIGN_EN
    chk("rst_parallel_out", 32'(parallel_out), 32'(0));
    chk("rst_valid", 32'(valid), 32'(0));
    chk("rst_locked", 32'(locked), 32'(0));
    chk("rst_state", 32'(dbg_state), 32'(SEARCH));

    // Acquire: 3 stray bits then three commas.
    drive(1'b1, 1'b1); drive(1'b0, 1'b1); drive(1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      send_word(COMMA_P);
      chk("acq_comma_det", 32'(comma_det), 32'(1));
      chk("acq_valid", 32'(valid), 32'(1));
      chk("acq_word", 32'(parallel_out), 32'(COMMA_P));
      chk("acq_locked", 32'(locked), 32'(c == 2));
    end

    send_word(DATA_A);
    chk("data_valid", 32'(valid), 32'(1));
    chk("data_word", 32'(parallel_out), 32'(DATA_A));
    chk("data_locked", 32'(locked), 32'(1));

    // Stall mid-word.
    send_bits(DATA_B, 9, 6);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0);
      chk("stall_valid", 32'(valid), 32'(0));
      chk("stall_hold", 32'(parallel_out), 32'(DATA_A));
    end
    send_bits(DATA_B, 5, 0);
    chk("stall_word", 32'(parallel_out), 32'(DATA_B));
    chk("stall_locked", 32'(locked), 32'(1));

    // Slip by one bit: four misplaced commas drop lock.
    drive(1'b0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      send_word(COMMA_P);
      chk("slip_locked", 32'(locked), 32'(c < 3));
    end
    for (int c = 0; c < 3; c++) begin
      send_word(COMMA_P);
      chk("relock_word", 32'(parallel_out), 32'(COMMA_P));
      chk("relock_locked", 32'(locked), 32'(c == 2));
    end

    // Reset mid-word discards the partial word and drops lock.
    send_bits(DATA_A, 9, 5);
    do_reset();
    chk("mid_rst_word", 32'(parallel_out), 32'(0));
    chk("mid_rst_locked", 32'(locked), 32'(0));
    chk("mid_rst_state", 32'(dbg_state), 32'(SEARCH));
    send_word(DATA_A);
    chk("search_no_valid", 32'(valid), 32'(0));
`else
    chk("rst_parallel_out", 32'(parallel_out), 32'(0));
    chk("rst_valid", 32'(valid), 32'(0));
    chk("rst_locked", 32'(locked), 32'(1));
    chk("rst_comma_det", 32'(comma_det), 32'(0));

    // Free-running words, no commas.
    for (int c = 0; c < 2; c++) begin
      send_bits(DATA_B, 9, 1);
      chk("free_pre_valid", 32'(valid), 32'(0));
      send_bits(DATA_B, 0, 0);
      chk("free_valid", 32'(valid), 32'(1));
      chk("free_word", 32'(parallel_out), 32'(DATA_B));
      chk("free_locked", 32'(locked), 32'(1));
      chk("free_comma_det", 32'(comma_det), 32'(0));
    end

    // Stall mid-word.
    send_bits(DATA_A, 9, 6);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0);
      chk("stall_valid", 32'(valid), 32'(0));
      chk("stall_hold", 32'(parallel_out), 32'(DATA_B));
    end
    send_bits(DATA_A, 5, 0);
    chk("stall_valid_end", 32'(valid), 32'(1));
    chk("stall_word", 32'(parallel_out), 32'(DATA_A));

    // Commas are ordinary data here.
    send_word(COMMA_P);
    chk("comma_as_data", 32'(parallel_out), 32'(COMMA_P));
    chk("comma_det_off", 32'(comma_det), 32'(0));

    // Reset mid-word: partial bits discarded, counter restarts.
    send_bits(DATA_B, 9, 5);
    do_reset();
    chk("mid_rst_word", 32'(parallel_out), 32'(0));
    chk("mid_rst_valid", 32'(valid), 32'(0));
    send_word(DATA_A);
    chk("post_rst_valid", 32'(valid), 32'(1));
    chk("post_rst_word", 32'(parallel_out), 32'(DATA_A));
`endif

    random_stream(80);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    chk("exp_q_drained", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
